// File: rtl/picosoc_led_ctrl_if.sv
// PicoRV32 native memory bus as seen by the LED controller.
// The CPU side drives the request and the LED controller side returns the acknowledge.
interface picosoc_led_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picosoc_led_ctrl.sv
// Memory-mapped LED controller for picosoc: static/blink per channel, PWM dimming, status readback.
// Optional PWM dimming is built only when LED_CTRL_PWM_EN is defined.
module picosoc_led_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
  parameter int          N_LEDS        = 10,
  parameter logic [31:0] BLINK_DEFAULT = 32'd25_000_000,
  parameter int          PWM_BITS      = 8
) (
  input  logic                clk,
  input  logic                reset,
  picosoc_led_ctrl_if.slave   bus,
  output logic [N_LEDS-1:0]   ledr
);

  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_VALUE  = 6'h01;
  localparam logic [5:0] W_BLINK  = 6'h02;
  localparam logic [5:0] W_HALF   = 6'h03;
  localparam logic [5:0] W_DUTY   = 6'h04;
  localparam logic [5:0] W_STATUS = 6'h05;

  // Handshake: a request is taken when mem_valid is high, the address hits the
  // window and no ack is outstanding; mem_ready then pulses for exactly the next
  // cycle with mem_rdata valid, and mem_rdata is 0 whenever mem_ready is 0.
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [5:0]  req_word;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic              en_q;
  logic [N_LEDS-1:0] value_q;
  logic [N_LEDS-1:0] blink_q;
  logic [31:0]       half_q;
  logic [31:0]       bcnt;
  logic              phase;
  logic              pwm_on;

`ifdef LED_CTRL_PWM_EN
  logic [PWM_BITS-1:0] pcnt;
  logic [PWM_BITS-1:0] duty_q;
`endif

  logic        sel;
  logic [5:0]  bus_word;
  logic [31:0] rd_word;
  logic [31:0] old_word;
  logic [31:0] wr_word;
  logic        wr_en;
  logic        wr_half;
  logic [31:0] half_eff;
  logic        terminal;
  logic [N_LEDS-1:0] lit;
  logic        unused_addr_lsb;

  assign bus.mem_ready   = ack_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus_word        = bus.mem_addr[7:2];
  assign unused_addr_lsb = ^bus.mem_addr[1:0];
  assign sel = bus.mem_valid & (bus.mem_addr[31:8] == BASE_ADDR[31:8]) & ~ack_q;

  function automatic logic [31:0] reg_view(input logic [5:0] w);
    logic [31:0] v;
    v = '0;
    case (w)
      W_CTRL:   v[0] = en_q;
      W_VALUE:  v[N_LEDS-1:0] = value_q;
      W_BLINK:  v[N_LEDS-1:0] = blink_q;
      W_HALF:   v = half_q;
`ifdef LED_CTRL_PWM_EN
      W_DUTY:   v[PWM_BITS-1:0] = duty_q;
`endif
      W_STATUS: v = 32'({ledr, phase});
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_word  = reg_view(bus_word);
    old_word = reg_view(req_word);
    wr_word  = merge_bytes(old_word, req_wdata, req_wstrb);
  end

  // The captured request is committed on the edge that ends the ack cycle, so a
  // reset during that cycle discards it.
  assign wr_en   = ack_q & (req_wstrb != 4'b0000);
  assign wr_half = wr_en & (req_word == W_HALF);

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      ack_q   <= sel;
      rdata_q <= sel ? rd_word : 32'h0;
      if (sel) begin
        req_word  <= bus_word;
        req_wdata <= bus.mem_wdata;
        req_wstrb <= bus.mem_wstrb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      value_q <= '0;
      blink_q <= '0;
      half_q  <= BLINK_DEFAULT;
`ifdef LED_CTRL_PWM_EN
      duty_q  <= '1;
`endif
    end else if (wr_en) begin
      case (req_word)
        W_CTRL:  en_q    <= wr_word[0];
        W_VALUE: value_q <= wr_word[N_LEDS-1:0];
        W_BLINK: blink_q <= wr_word[N_LEDS-1:0];
        W_HALF:  half_q  <= wr_word;
`ifdef LED_CTRL_PWM_EN
        W_DUTY:  duty_q  <= wr_word[PWM_BITS-1:0];
`endif
        default: ;
      endcase
    end
  end

  // A programmed half-period of 0 behaves like 1 so the phase toggles every cycle.
  assign half_eff = (half_q == 32'h0) ? 32'd1 : half_q;
  assign terminal = (bcnt == half_eff - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (wr_half) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (terminal) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 32'd1;
    end
  end

`ifdef LED_CTRL_PWM_EN
  always_ff @(posedge clk) begin
    if (reset) pcnt <= '0;
    else       pcnt <= pcnt + 1'b1;
  end

  // Full-scale duty means always on rather than one dark slot per period.
  assign pwm_on = (pcnt < duty_q) | (&duty_q);
`else
  assign pwm_on = 1'b1;
`endif

  assign lit = {N_LEDS{en_q & pwm_on}} & value_q & (~blink_q | {N_LEDS{phase}});

  always_ff @(posedge clk) begin
    if (reset) ledr <= '0;
    else       ledr <= lit;
  end

endmodule

// File: tb/tb_picosoc_led_ctrl.sv
// Directed bench for picosoc_led_ctrl: a register/LED vector table plus
// hand-written sequences for blink timing, PWM, bus corner cases and reset.
module tb_picosoc_led_ctrl;

  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef LED_CTRL_PWM_EN
  localparam logic [31:0] DUTY_RST = 32'h0000_00FF;
`else
  localparam logic [31:0] DUTY_RST = 32'h0000_0000;
`endif

  logic       clk;
  logic       reset;
  logic [9:0] ledr;

  picosoc_led_ctrl_if bus();

  picosoc_led_ctrl #(
    .BASE_ADDR     (BASE),
    .N_LEDS        (10),
    .BLINK_DEFAULT (32'd25_000_000),
    .PWM_BITS      (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ledr  (ledr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [9:0]  exp_ledr;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input logic [31:0] er, input logic [9:0] el);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wstrb = st; v.exp_rdata = er; v.exp_ledr = el;
    vq.push_back(v);
  endtask

  // driver: one bus access, bounded to 10 cycles waiting for the ack
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic acked);
    acked = 1'b0;
    rdata = '0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        acked = 1'b1;
        rdata = bus.mem_rdata;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input string name);
    logic [31:0] rd;
    logic        ak;
    bus_xfer(addr, wdata, 4'hF, rd, ak);
    check({name, "_ack"}, {31'b0, ak}, 32'd1);
  endtask

  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    logic        ak;
    bus_xfer(addr, 32'h0, 4'h0, rd, ak);
    check({name, "_ack"}, {31'b0, ak}, 32'd1);
    check(name, rd, exp);
  endtask

  logic [31:0] rdata;
  logic        acked;
  logic        s [0:39];
  logic [9:0]  upper_or;
  int          t0;
  int          bad;
  int          cnt;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;

    // reset held for 5 cycles with a read of CTRL pending on the bus
    reset = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d_ready", i), {31'b0, bus.mem_ready}, 32'd0);
      check($sformatf("rst%0d_ledr", i), {22'b0, ledr}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mem_valid = 1'b0;

    // addr, wdata, wstrb, expected read data (reads only), expected ledr afterwards
    add_vec(BASE + 32'h00, 32'h0,         4'h0, 32'h0,         10'h000);
    add_vec(BASE + 32'h04, 32'h0,         4'h0, 32'h0,         10'h000);
    add_vec(BASE + 32'h08, 32'h0,         4'h0, 32'h0,         10'h000);
    add_vec(BASE + 32'h0C, 32'h0,         4'h0, 32'h017D_7840, 10'h000);
    add_vec(BASE + 32'h10, 32'h0,         4'h0, DUTY_RST,      10'h000);
    add_vec(BASE + 32'h14, 32'h0,         4'h0, 32'h001,       10'h000);
    add_vec(BASE + 32'h00, 32'h1,         4'hF, 32'h0,         10'h000);
    add_vec(BASE + 32'h04, 32'h2A5,       4'hF, 32'h0,         10'h2A5);
    add_vec(BASE + 32'h00, 32'h0,         4'h0, 32'h1,         10'h2A5);
    add_vec(BASE + 32'h04, 32'h0,         4'h0, 32'h2A5,       10'h2A5);
    add_vec(BASE + 32'h14, 32'h0,         4'h0, 32'h54B,       10'h2A5);
    add_vec(BASE + 32'h04, 32'hFFFF_FF00, 4'h2, 32'h0,         10'h3A5);
    add_vec(BASE + 32'h04, 32'h0,         4'h0, 32'h3A5,       10'h3A5);
    add_vec(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,         10'h3A5);
    add_vec(BASE + 32'h14, 32'h0,         4'h0, 32'h74B,       10'h3A5);
    add_vec(BASE + 32'h18, 32'h0,         4'h0, 32'h0,         10'h3A5);
    add_vec(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0,         10'h3A5);
    add_vec(BASE + 32'h20, 32'h0,         4'h0, 32'h0,         10'h3A5);
    add_vec(BASE + 32'h00, 32'h0,         4'hF, 32'h0,         10'h000);
    add_vec(BASE + 32'h14, 32'h0,         4'h0, 32'h001,       10'h000);
    add_vec(BASE + 32'h00, 32'h1,         4'hF, 32'h0,         10'h3A5);

    for (int i = 0; i < vq.size(); i++) begin
      bus_xfer(vq[i].addr, vq[i].wdata, vq[i].wstrb, rdata, acked);
      check($sformatf("vec%0d_ack", i), {31'b0, acked}, 32'd1);
      if (vq[i].wstrb == 4'h0) check($sformatf("vec%0d_rdata", i), rdata, vq[i].exp_rdata);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_ledr", i), {22'b0, ledr}, {22'b0, vq[i].exp_ledr});
      check($sformatf("vec%0d_idle_rdata", i), bus.mem_rdata, 32'h0);
    end

    // held request: one ack every second cycle
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h04;
    bus.mem_wstrb = 4'h0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(bus.mem_ready);
      check($sformatf("b2b%0d_ready", i), {31'b0, bus.mem_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.mem_valid = 1'b0;
    check("b2b_ack_count", cnt, 32'd3);

    // outside the window: no ack, no effect
    bus_xfer(BASE + 32'h100, 32'h0, 4'h0, rdata, acked);
    check("outside_rd_noack", {31'b0, acked}, 32'd0);
    bus_xfer(BASE + 32'h104, 32'h0, 4'hF, rdata, acked);
    check("outside_wr_noack", {31'b0, acked}, 32'd0);
    rd_check(BASE + 32'h04, 32'h3A5, "outside_value_kept");

    // blink with a 4-cycle half period on channel 0
    wr(BASE + 32'h0C, 32'd4, "half4");
    wr(BASE + 32'h08, 32'h001, "blink");
    wr(BASE + 32'h04, 32'h001, "value1");
    repeat (2) @(posedge clk);
    upper_or = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      s[i] = ledr[0];
      upper_or |= {ledr[9:1], 1'b0};
    end
    t0 = -1;
    for (int i = 1; i < 40; i++) begin
      if (t0 < 0 && s[i] != s[i-1]) t0 = i;
    end
    check("blink_first_toggle_in_range", {31'b0, (t0 >= 1 && t0 <= 4)}, 32'd1);
    bad = 0;
    if (t0 >= 1) begin
      for (int i = t0; i < 40; i++) begin
        if (s[i] != (s[t0] ^ (((i - t0) / 4) % 2 == 1))) bad++;
      end
    end
    check("blink_period4", bad, 32'd0);
    check("blink_upper_dark", {22'b0, upper_or}, 32'd0);
    rd_check(BASE + 32'h0C, 32'd4, "half_readback");

    // half period 0 acts as 1: toggles every cycle
    wr(BASE + 32'h0C, 32'd0, "half0");
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      s[i] = ledr[0];
    end
    bad = 0;
    for (int i = 1; i < 10; i++) if (s[i] == s[i-1]) bad++;
    check("blink_half0_every_cycle", bad, 32'd0);

    // PWM duty over a full 256-cycle window
    wr(BASE + 32'h08, 32'h0, "blink_off");
    wr(BASE + 32'h10, 32'd64, "duty64");
    repeat (2) @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(ledr[0]);
    end
`ifdef LED_CTRL_PWM_EN
    check("pwm_duty64_lit", cnt, 32'd64);
    rd_check(BASE + 32'h10, 32'd64, "duty_readback");
    wr(BASE + 32'h10, 32'd0, "duty0");
    repeat (2) @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(ledr[0]);
    end
    check("pwm_duty0_lit", cnt, 32'd0);
`else
    check("nopwm_always_lit", cnt, 32'd256);
    rd_check(BASE + 32'h10, 32'd0, "nopwm_duty_reads0");
`endif

    // reset asserted during the ack cycle of a VALUE write
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h04;
    bus.mem_wdata = 32'h3FF;
    bus.mem_wstrb = 4'hF;
    acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        acked = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    check("rstack_ack_seen", {31'b0, acked}, 32'd1);
    @(posedge clk);
    #1;
    check("rstack_ready", {31'b0, bus.mem_ready}, 32'd0);
    check("rstack_ledr", {22'b0, ledr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_check(BASE + 32'h04, 32'h0, "rstack_value");
    rd_check(BASE + 32'h00, 32'h0, "rstack_ctrl");
    repeat (2) @(posedge clk);
    #1;
    check("rstack_ledr_after", {22'b0, ledr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
